// File: rtl/execute_stage_pkg.sv
// Shared constants and types for the EX stage.
// ALU op codes, branch compare codes, MIPS opcodes, divider states.
package execute_stage_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_DIV = 3'b100;
   localparam logic [2:0] ALU_REM = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Branch compare selectors reuse ALUctr encodings
   localparam logic [2:0] BR_EQ = 3'b101;
   localparam logic [2:0] BR_NE = 3'b110;

   localparam logic [5:0] OP_R   = 6'd0;
   localparam logic [5:0] OP_J   = 6'd2;
   localparam logic [5:0] OP_BEQ = 6'd4;
   localparam logic [5:0] OP_BNE = 6'd5;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_SW  = 6'd43;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } div_state_e;

endpackage

// File: rtl/execute_stage_seq_divider.sv
// Signed iterative restoring divider, one quotient bit per cycle.
// Works on magnitudes and applies the result signs on the way out.
module seq_divider #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [DW-1:0] remainder
);
   import execute_stage_pkg::*;

   localparam int CW = $clog2(DW);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rem_q, rem_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [DW-1:0] dvs_q, dvs_d;
   logic          sq_q, sq_d;
   logic          sr_q, sr_d;
   logic          dz_q, dz_d;
   logic [DW:0]   shl;
   logic [DW:0]   diff;
   logic [DW-1:0] a_mag;
   logic [DW-1:0] b_mag;

   always_comb begin
      a_mag   = dividend[DW-1] ? -dividend : dividend;
      b_mag   = divisor[DW-1] ? -divisor : divisor;
      shl     = {rem_q, quo_q[DW-1]};
      diff    = shl - {1'b0, dvs_q};
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      dz_d    = dz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BUSY;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = a_mag;
               dvs_d   = b_mag;
               sq_d    = dividend[DW-1] ^ divisor[DW-1];
               sr_d    = dividend[DW-1];
               dz_d    = (divisor == '0);
            end
         end
         BUSY: begin
            // Restore on negative trial difference
            rem_d = diff[DW] ? shl[DW-1:0] : diff[DW-1:0];
            quo_d = {quo_q[DW-2:0], ~diff[DW]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(DW - 1)) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         dz_q    <= dz_d;
      end
   end

   assign busy      = (state_q == BUSY);
   assign done      = (state_q == DONE);
   assign quotient  = dz_q ? '1 : (sq_q ? -quo_q : quo_q);
   assign remainder = sr_q ? -rem_q : rem_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage: ALU, branch compare/target, jump passthrough, XM register.
// Divides run on the iterative divider and stall upstream meanwhile.
module execute_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemtoReg,
   input  logic          RegWrite,
   input  logic          MemRead,
   input  logic          MemWrite,
   input  logic          branch,
   input  logic          jump,
   input  logic [2:0]    ALUctr,
   input  logic [DW-1:0] A,
   input  logic [DW-1:0] B,
   input  logic [DW-1:0] MD,
   input  logic [DW-1:0] NPC,
   input  logic [DW-1:0] JT,
   input  logic [15:0]   imm,
   input  logic [RW-1:0] RD,
   output logic          stall,
   output logic          XM_MemtoReg,
   output logic          XM_RegWrite,
   output logic          XM_MemRead,
   output logic          XM_MemWrite,
   output logic [RW-1:0] XM_RD,
   output logic [DW-1:0] ALUout,
   output logic [DW-1:0] XM_MD,
   output logic [DW-1:0] XM_BT,
   output logic          XM_branch_taken,
   output logic          XM_jump,
   output logic [DW-1:0] XM_JT
);
   import execute_stage_pkg::*;

   logic          div_op;
   logic          div_start;
   logic          div_busy;
   logic          div_done;
   logic [DW-1:0] div_quo;
   logic [DW-1:0] div_rem;
   logic [DW-1:0] alu_res;
   logic          taken;
   logic [DW-1:0] bt;

   logic          m2r_q, m2r_d;
   logic          rw_q, rw_d;
   logic          mr_q, mr_d;
   logic          mw_q, mw_d;
   logic [RW-1:0] rd_q, rd_d;
   logic [DW-1:0] alu_q, alu_d;
   logic [DW-1:0] md_q, md_d;
   logic [DW-1:0] bt_q, bt_d;
   logic          tk_q, tk_d;
   logic          jmp_q, jmp_d;
   logic [DW-1:0] jt_q, jt_d;

   assign div_op    = ~branch & ((ALUctr == ALU_DIV) | (ALUctr == ALU_REM));
   assign div_start = rst & div_op & ~div_busy & ~div_done;
   assign stall     = rst & div_op & ~div_done;

   seq_divider #(.DW(DW)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .dividend  (A),
      .divisor   (B),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      alu_res = '0;
      if (branch) begin
         alu_res = A - B;
      end else begin
         case (ALUctr)
            ALU_ADD: alu_res = A + B;
            ALU_SUB: alu_res = A - B;
            ALU_AND: alu_res = A & B;
            ALU_OR:  alu_res = A | B;
            ALU_SLT: alu_res = {{(DW-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_DIV: alu_res = div_quo;
            ALU_REM: alu_res = div_rem;
            default: alu_res = '0;
         endcase
      end
      taken = branch & (((ALUctr == BR_EQ) & (A == B)) |
                        ((ALUctr == BR_NE) & (A != B)));
      bt    = NPC + {{(DW-18){imm[15]}}, imm, 2'b00};
   end

   // A stalled cycle hands a bubble to the memory stage
   always_comb begin
      m2r_d = MemtoReg & ~stall;
      rw_d  = RegWrite & ~stall;
      mr_d  = MemRead & ~stall;
      mw_d  = MemWrite & ~stall;
      tk_d  = taken & ~stall;
      jmp_d = jump & ~stall;
      rd_d  = RD;
      alu_d = alu_res;
      md_d  = MD;
      bt_d  = bt;
      jt_d  = JT;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         m2r_q <= 1'b0;
         rw_q  <= 1'b0;
         mr_q  <= 1'b0;
         mw_q  <= 1'b0;
         rd_q  <= '0;
         alu_q <= '0;
         md_q  <= '0;
         bt_q  <= '0;
         tk_q  <= 1'b0;
         jmp_q <= 1'b0;
         jt_q  <= '0;
      end else begin
         m2r_q <= m2r_d;
         rw_q  <= rw_d;
         mr_q  <= mr_d;
         mw_q  <= mw_d;
         rd_q  <= rd_d;
         alu_q <= alu_d;
         md_q  <= md_d;
         bt_q  <= bt_d;
         tk_q  <= tk_d;
         jmp_q <= jmp_d;
         jt_q  <= jt_d;
      end
   end

   assign XM_MemtoReg     = m2r_q;
   assign XM_RegWrite     = rw_q;
   assign XM_MemRead      = mr_q;
   assign XM_MemWrite     = mw_q;
   assign XM_RD           = rd_q;
   assign ALUout          = alu_q;
   assign XM_MD           = md_q;
   assign XM_BT           = bt_q;
   assign XM_branch_taken = tk_q;
   assign XM_jump         = jmp_q;
   assign XM_JT           = jt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage.
// Hand-computed expectations, one shared compare task.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemtoReg, RegWrite, MemRead, MemWrite, branch, jump;
   logic [2:0]  ALUctr;
   logic [31:0] A, B, MD, NPC, JT;
   logic [15:0] imm;
   logic [4:0]  RD;
   logic        stall;
   logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
   logic [4:0]  XM_RD;
   logic [31:0] ALUout, XM_MD, XM_BT, XM_JT;
   logic        XM_branch_taken, XM_jump;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   execute_stage #(.DW(32), .RW(5)) dut (
      .clk             (clk),
      .rst             (rst),
      .MemtoReg        (MemtoReg),
      .RegWrite        (RegWrite),
      .MemRead         (MemRead),
      .MemWrite        (MemWrite),
      .branch          (branch),
      .jump            (jump),
      .ALUctr          (ALUctr),
      .A               (A),
      .B               (B),
      .MD              (MD),
      .NPC             (NPC),
      .JT              (JT),
      .imm             (imm),
      .RD              (RD),
      .stall           (stall),
      .XM_MemtoReg     (XM_MemtoReg),
      .XM_RegWrite     (XM_RegWrite),
      .XM_MemRead      (XM_MemRead),
      .XM_MemWrite     (XM_MemWrite),
      .XM_RD           (XM_RD),
      .ALUout          (ALUout),
      .XM_MD           (XM_MD),
      .XM_BT           (XM_BT),
      .XM_branch_taken (XM_branch_taken),
      .XM_jump         (XM_jump),
      .XM_JT           (XM_JT)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic nop();
      {MemtoReg, RegWrite, MemRead, MemWrite, branch, jump} = '0;
      ALUctr = 3'b010;
      A = '0; B = '0; MD = '0; NPC = '0; JT = '0; imm = '0; RD = '0;
   endtask

   task automatic alu(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp,
                      input string tag);
      nop();
      ALUctr = op; A = a; B = b; RD = 5'd7; RegWrite = 1'b1;
      #1;
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      tick();
      chk(tag, ALUout, exp);
   endtask

   task automatic run_div(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string tag);
      int n;
      bit rw_seen;
      nop();
      ALUctr = op; A = a; B = b; RD = 5'd3; RegWrite = 1'b1;
      #1;
      n = 0;
      rw_seen = 1'b0;
      while (stall && n < 64) begin
         tick();
         n++;
         if (XM_RegWrite) rw_seen = 1'b1;
      end
      chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
      chk({tag, "_bubble"}, 32'(rw_seen), 32'd0);
      tick();
      chk(tag, ALUout, exp);
      chk({tag, "_rw"}, 32'(XM_RegWrite), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      nop();
      tick();
      tick();
      chk("rst_alu", ALUout, 32'd0);
      chk("rst_rw", 32'(XM_RegWrite), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      rst = 1'b1;

      alu(3'b010, 32'd7, 32'd5, 32'd12, "add");
      chk("add_rd", 32'(XM_RD), 32'd7);
      chk("add_rw", 32'(XM_RegWrite), 32'd1);
      nop();
      ALUctr = 3'b010; A = 32'd7; B = 32'd5; RD = 5'd9; RegWrite = 1'b1;
      tick();
      chk("add_rd9", 32'(XM_RD), 32'd9);

      alu(3'b111, 32'hFFFF_FFFD, 32'd2, 32'd1, "slt_neg");
      alu(3'b111, 32'd2, 32'hFFFF_FFFD, 32'd0, "slt_pos");
      alu(3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, "and");
      alu(3'b001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, "or");
      alu(3'b110, 32'd5, 32'd7, 32'hFFFF_FFFE, "sub");
      alu(3'b011, 32'd5, 32'd7, 32'd0, "bad_op");
      alu(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap");

      nop();
      ALUctr = 3'b010; A = 32'h100; B = 32'hFFFF_FFFC;
      MD = 32'hDEAD_BEEF; MemRead = 1'b1; MemtoReg = 1'b1;
      RegWrite = 1'b1; jump = 1'b1; JT = 32'h1234;
      tick();
      chk("lw_addr", ALUout, 32'h0000_00FC);
      chk("lw_md", XM_MD, 32'hDEAD_BEEF);
      chk("lw_mr", 32'(XM_MemRead), 32'd1);
      chk("lw_m2r", 32'(XM_MemtoReg), 32'd1);
      chk("jump", 32'(XM_jump), 32'd1);
      chk("jt", XM_JT, 32'h1234);

      nop();
      branch = 1'b1; ALUctr = 3'b101; A = 32'd4; B = 32'd4;
      NPC = 32'h40; imm = 16'hFFFE;
      tick();
      chk("beq_taken", 32'(XM_branch_taken), 32'd1);
      chk("beq_bt", XM_BT, 32'h38);
      chk("beq_alu", ALUout, 32'd0);
      ALUctr = 3'b110;
      tick();
      chk("bne_eq", 32'(XM_branch_taken), 32'd0);
      A = 32'd5;
      imm = 16'h0003;
      tick();
      chk("bne_ne", 32'(XM_branch_taken), 32'd1);
      chk("bne_alu", ALUout, 32'd1);
      chk("bne_bt", XM_BT, 32'h4C);
      ALUctr = 3'b010;
      tick();
      chk("br_other", 32'(XM_branch_taken), 32'd0);

      run_div(3'b100, 32'd100, 32'd7, 32'd14, "div");
      run_div(3'b101, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_neg");
      run_div(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "div_neg");
      run_div(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_zero");
      run_div(3'b101, 32'd5, 32'd0, 32'd5, "rem_zero");
      run_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      run_div(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

      nop();
      ALUctr = 3'b100; A = 32'd100; B = 32'd7; RegWrite = 1'b1;
      MD = 32'h55; NPC = 32'h4; JT = 32'h8; jump = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      chk("mid_stall", 32'(stall), 32'd1);
      rst = 1'b0;
      tick();
      chk("mrst_alu", ALUout, 32'd0);
      chk("mrst_md", XM_MD, 32'd0);
      chk("mrst_bt", XM_BT, 32'd0);
      chk("mrst_jt", XM_JT, 32'd0);
      chk("mrst_stall", 32'(stall), 32'd0);
      rst = 1'b1;
      alu(3'b010, 32'd1, 32'd1, 32'd2, "post_rst_add");
      run_div(3'b100, 32'd100, 32'd7, 32'd14, "post_rst_div");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
